// File: rtl/core_ex_ctrl_pkg.sv
// core_ex_ctrl_pkg: shared types and constants for the execute-stage controller.
//   ex_state_t : controller state (IDLE / WAIT / FULL), 2 bits
//   EX_RD_W    : destination-register index width
package core_ex_ctrl_pkg;

    localparam int unsigned EX_RD_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        FULL = 2'd2
    } ex_state_t;

endpackage

// File: rtl/core_ex_ctrl_if.sv
// core_ex_ctrl_if: handshake bundle between ID/EX, the shared ALU, EX/MEM and
// the execute controller.
//   de_*  : ID/EX instruction handshake (valid/ready, multi-cycle flag, rd)
//   alu_* : ALU result, start/done/kill pulses
//   em_*  : EX/MEM payload handshake (valid/ready, data, rd)
// Modports: slave = controller side, master = surrounding pipeline side.
interface core_ex_ctrl_if;
    import core_ex_ctrl_pkg::*;

    logic               de_valid;
    logic               de_ready;
    logic               de_multi;
    logic [EX_RD_W-1:0] de_rd;
    logic [31:0]        alu_out;
    logic               alu_start;
    logic               alu_done;
    logic               alu_kill;
    logic               em_valid;
    logic               em_ready;
    logic [31:0]        em_data;
    logic [EX_RD_W-1:0] em_rd;

    modport slave (
        input  de_valid, de_multi, de_rd, alu_out, alu_done, em_ready,
        output de_ready, alu_start, alu_kill, em_valid, em_data, em_rd
    );

    modport master (
        output de_valid, de_multi, de_rd, alu_out, alu_done, em_ready,
        input  de_ready, alu_start, alu_kill, em_valid, em_data, em_rd
    );

endinterface

// File: rtl/core_sat_cnt.sv
// core_sat_cnt: W-bit up-counter that sticks at all-ones.
//   clk, rest : clock, asynchronous active-low reset
//   clr       : synchronous clear, takes priority over en
//   en        : count enable
//   cnt       : current count
module core_sat_cnt #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rest,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/core_ex_ctrl.sv
// core_ex_ctrl: execute-stage sequencing controller.
//   clk, rest  : clock, asynchronous active-low reset
//   ex_if      : ID/EX, ALU and EX/MEM handshakes (slave side)
//   flush_en   : kill younger work; aborts an in-flight multi-cycle op
//   busy       : a multi-cycle op is in flight (WAIT)
//   timeout    : sticky, set when the ALU watchdog aborts an op
//   stat_clr   : clears stall_cnt and timeout
//   stall_cnt  : saturating count of WAIT and back-pressured FULL cycles
module core_ex_ctrl
    import core_ex_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 64,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rest,
    core_ex_ctrl_if.slave    ex_if,
    input  logic             flush_en,
    output logic             busy,
    output logic             timeout,
    input  logic             stat_clr,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);

    ex_state_t          state;
    logic               em_valid_q;
    logic [31:0]        em_data_q;
    logic [EX_RD_W-1:0] em_rd_q;
    logic [EX_RD_W-1:0] wait_rd;
    logic               alu_start_q;
    logic               alu_kill_q;
    logic               busy_q;
    logic               timeout_q;
    logic [WD_W-1:0]    wd_cnt;

    logic de_ready;
    logic accept;
    logic wd_hit;
    logic stall;

    assign de_ready = !flush_en &&
                      ((state == IDLE) || ((state == FULL) && ex_if.em_ready));
    assign accept   = ex_if.de_valid && de_ready;
    assign stall    = (state == WAIT) || ((state == FULL) && !ex_if.em_ready);

    // Watchdog is cleared on multi-cycle accept, so it reads 0 in the first
    // WAIT cycle; reaching TIMEOUT_CYC-1 means TIMEOUT_CYC WAIT cycles elapsed.
    assign wd_hit = (wd_cnt == WD_W'(TIMEOUT_CYC - 1));

    core_sat_cnt #(.W(WD_W)) u_wd_cnt (
        .clk  (clk),
        .rest (rest),
        .clr  (accept && ex_if.de_multi),
        .en   (state == WAIT),
        .cnt  (wd_cnt)
    );

    core_sat_cnt #(.W(CNT_W)) u_stall_cnt (
        .clk  (clk),
        .rest (rest),
        .clr  (stat_clr),
        .en   (stall),
        .cnt  (stall_cnt)
    );

    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            state       <= IDLE;
            em_valid_q  <= 1'b0;
            em_data_q   <= '0;
            em_rd_q     <= '0;
            wait_rd     <= '0;
            alu_start_q <= 1'b0;
            alu_kill_q  <= 1'b0;
            busy_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            alu_start_q <= 1'b0;
            alu_kill_q  <= 1'b0;
            if (stat_clr) begin
                timeout_q <= 1'b0;
            end
            unique case (state)
                IDLE, FULL: begin
                    if (accept) begin
                        if (ex_if.de_multi) begin
                            wait_rd     <= ex_if.de_rd;
                            alu_start_q <= 1'b1;
                            state       <= WAIT;
                            em_valid_q  <= 1'b0;
                            busy_q      <= 1'b1;
                        end else begin
                            em_data_q  <= ex_if.alu_out;
                            em_rd_q    <= ex_if.de_rd;
                            state      <= FULL;
                            em_valid_q <= 1'b1;
                            busy_q     <= 1'b0;
                        end
                    end else if ((state == FULL) && ex_if.em_ready) begin
                        state      <= IDLE;
                        em_valid_q <= 1'b0;
                        busy_q     <= 1'b0;
                    end
                end
                WAIT: begin
                    // flush beats a same-cycle alu_done; done beats the watchdog
                    if (flush_en) begin
                        alu_kill_q <= 1'b1;
                        state      <= IDLE;
                        busy_q     <= 1'b0;
                    end else if (ex_if.alu_done) begin
                        em_data_q  <= ex_if.alu_out;
                        em_rd_q    <= wait_rd;
                        state      <= FULL;
                        em_valid_q <= 1'b1;
                        busy_q     <= 1'b0;
                    end else if (wd_hit) begin
                        alu_kill_q <= 1'b1;
                        timeout_q  <= 1'b1;
                        state      <= IDLE;
                        busy_q     <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    em_valid_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign ex_if.de_ready  = de_ready;
    assign ex_if.alu_start = alu_start_q;
    assign ex_if.alu_kill  = alu_kill_q;
    assign ex_if.em_valid  = em_valid_q;
    assign ex_if.em_data   = em_data_q;
    assign ex_if.em_rd     = em_rd_q;
    assign busy            = busy_q;
    assign timeout         = timeout_q;

endmodule

// File: tb/tb_core_ex_ctrl.sv
// tb_core_ex_ctrl: scoreboard bench for core_ex_ctrl (TIMEOUT_CYC=8, CNT_W=4).
// Expected payloads are queued when the producing stimulus is driven and
// compared whenever EX/MEM hands a payload over.
module tb_core_ex_ctrl;

    logic       clk = 1'b0;
    logic       rest;
    logic       flush_en;
    logic       busy;
    logic       timeout;
    logic       stat_clr;
    logic [3:0] stall_cnt;

    core_ex_ctrl_if ex_if();

    core_ex_ctrl #(
        .TIMEOUT_CYC (8),
        .CNT_W       (4)
    ) dut (
        .clk       (clk),
        .rest      (rest),
        .ex_if     (ex_if),
        .flush_en  (flush_en),
        .busy      (busy),
        .timeout   (timeout),
        .stat_clr  (stat_clr),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned start_seen = 0;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  rd;
    } payload_t;

    payload_t sb[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard consumer: a transfer happens on em_valid & em_ready.
    always @(negedge clk) begin
        if (rest && ex_if.em_valid && ex_if.em_ready) begin
            check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                payload_t p;
                p = sb.pop_front();
                check("sb_data", ex_if.em_data, p.data);
                check("sb_rd", 32'(ex_if.em_rd), 32'(p.rd));
            end
        end
        if (rest && ex_if.alu_start) begin
            start_seen++;
        end
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_em_valid"}, 32'(ex_if.em_valid), 32'd0);
        check({tag, "_em_data"}, ex_if.em_data, 32'd0);
        check({tag, "_em_rd"}, 32'(ex_if.em_rd), 32'd0);
        check({tag, "_alu_start"}, 32'(ex_if.alu_start), 32'd0);
        check({tag, "_alu_kill"}, 32'(ex_if.alu_kill), 32'd0);
        check({tag, "_timeout"}, 32'(timeout), 32'd0);
        check({tag, "_stall_cnt"}, 32'(stall_cnt), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    logic [31:0] vals [3];
    logic [31:0] held_data;
    logic [4:0]  held_rd;
    int unsigned s0;
    int unsigned bcnt;
    int unsigned n_wait;
    int unsigned guard;

    initial begin
        vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33;
        rest           = 1'b0;
        flush_en       = 1'b0;
        stat_clr       = 1'b0;
        ex_if.de_valid = 1'b0;
        ex_if.de_multi = 1'b0;
        ex_if.de_rd    = '0;
        ex_if.alu_out  = '0;
        ex_if.alu_done = 1'b0;
        ex_if.em_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("rst");
        check("rst_de_ready", 32'(ex_if.de_ready), 32'd1);
        rest = 1'b1;
        step();

        // Single-cycle ops back-to-back, one result per cycle.
        ex_if.em_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ex_if.de_valid = 1'b1;
            ex_if.de_multi = 1'b0;
            ex_if.de_rd    = 5'(i + 1);
            ex_if.alu_out  = vals[i];
            #1;
            check("b2b_de_ready", 32'(ex_if.de_ready), 32'd1);
            sb.push_back('{data: vals[i], rd: 5'(i + 1)});
            step();
            check("b2b_em_valid", 32'(ex_if.em_valid), 32'd1);
            check("b2b_em_data", ex_if.em_data, vals[i]);
        end
        ex_if.de_valid = 1'b0;
        step();
        check("b2b_idle", 32'(ex_if.em_valid), 32'd0);
        check("b2b_stall", 32'(stall_cnt), 32'd0);

        // Multi-cycle op: rd=7, done on the 5th WAIT cycle.
        s0 = start_seen;
        ex_if.de_valid = 1'b1;
        ex_if.de_multi = 1'b1;
        ex_if.de_rd    = 5'd7;
        ex_if.em_ready = 1'b0;
        #1;
        check("mc_de_ready", 32'(ex_if.de_ready), 32'd1);
        step();
        ex_if.de_valid = 1'b0;
        ex_if.de_multi = 1'b0;
        bcnt = 0;
        for (int c = 1; c <= 5; c++) begin
            if (busy) bcnt++;
            check("mc_wait_de_ready", 32'(ex_if.de_ready), 32'd0);
            check("mc_wait_em_valid", 32'(ex_if.em_valid), 32'd0);
            if (c == 5) begin
                ex_if.alu_done = 1'b1;
                ex_if.alu_out  = 32'hDEAD;
                sb.push_back('{data: 32'hDEAD, rd: 5'd7});
            end
            step();
            ex_if.alu_done = 1'b0;
        end
        check("mc_busy_cycles", bcnt, 32'd5);
        check("mc_busy_low", 32'(busy), 32'd0);
        check("mc_start_pulses", start_seen - s0, 32'd1);
        check("mc_em_valid", 32'(ex_if.em_valid), 32'd1);
        check("mc_em_data", ex_if.em_data, 32'hDEAD);
        check("mc_em_rd", 32'(ex_if.em_rd), 32'd7);
        check("mc_stall", 32'(stall_cnt), 32'd5);

        // Back-pressure: hold FULL four cycles with a competing instruction.
        held_data = 32'hDEAD;
        held_rd   = 5'd7;
        ex_if.de_valid = 1'b1;
        ex_if.alu_out  = 32'h5555;
        ex_if.de_rd    = 5'd2;
        for (int c = 0; c < 4; c++) begin
            #1;
            check("bp_de_ready", 32'(ex_if.de_ready), 32'd0);
            step();
            check("bp_em_data", ex_if.em_data, held_data);
            check("bp_em_rd", 32'(ex_if.em_rd), 32'(held_rd));
            check("bp_em_valid", 32'(ex_if.em_valid), 32'd1);
        end
        check("bp_stall", 32'(stall_cnt), 32'd9);
        ex_if.de_valid = 1'b0;
        ex_if.em_ready = 1'b1;
        step();
        check("bp_drained", 32'(ex_if.em_valid), 32'd0);

        // Flush arriving together with alu_done.
        ex_if.de_valid = 1'b1;
        ex_if.de_multi = 1'b1;
        ex_if.de_rd    = 5'd3;
        step();
        ex_if.de_valid = 1'b0;
        ex_if.de_multi = 1'b0;
        step();
        ex_if.alu_done = 1'b1;
        ex_if.alu_out  = 32'hBAD0;
        flush_en       = 1'b1;
        step();
        ex_if.alu_done = 1'b0;
        flush_en       = 1'b0;
        check("fl_kill", 32'(ex_if.alu_kill), 32'd1);
        check("fl_busy", 32'(busy), 32'd0);
        check("fl_em_valid", 32'(ex_if.em_valid), 32'd0);
        step();
        check("fl_kill_pulse", 32'(ex_if.alu_kill), 32'd0);
        check("fl_em_valid2", 32'(ex_if.em_valid), 32'd0);

        // Watchdog: no alu_done, abort after 8 WAIT cycles.
        ex_if.de_valid = 1'b1;
        ex_if.de_multi = 1'b1;
        ex_if.de_rd    = 5'd9;
        step();
        ex_if.de_valid = 1'b0;
        ex_if.de_multi = 1'b0;
        n_wait = 0;
        guard  = 0;
        while (!ex_if.alu_kill && guard < 20) begin
            if (busy) n_wait++;
            guard++;
            step();
        end
        check("wd_kill", 32'(ex_if.alu_kill), 32'd1);
        check("wd_wait_cycles", n_wait, 32'd8);
        check("wd_timeout", 32'(timeout), 32'd1);
        check("wd_em_valid", 32'(ex_if.em_valid), 32'd0);
        repeat (3) step();
        check("wd_sticky", 32'(timeout), 32'd1);
        check("wd_kill_pulse", 32'(ex_if.alu_kill), 32'd0);
        stat_clr = 1'b1;
        step();
        stat_clr = 1'b0;
        check("wd_clr_timeout", 32'(timeout), 32'd0);
        check("wd_clr_stall", 32'(stall_cnt), 32'd0);

        // Saturation: FULL back-pressured for 20 cycles.
        ex_if.em_ready = 1'b0;
        ex_if.de_valid = 1'b1;
        ex_if.de_multi = 1'b0;
        ex_if.de_rd    = 5'd12;
        ex_if.alu_out  = 32'hA5A5_0001;
        sb.push_back('{data: 32'hA5A5_0001, rd: 5'd12});
        step();
        ex_if.de_valid = 1'b0;
        repeat (20) step();
        check("sat_stall", 32'(stall_cnt), 32'hF);
        ex_if.em_ready = 1'b1;
        step();

        // Asynchronous reset in the middle of WAIT.
        ex_if.de_valid = 1'b1;
        ex_if.de_multi = 1'b1;
        ex_if.de_rd    = 5'd4;
        step();
        ex_if.de_valid = 1'b0;
        ex_if.de_multi = 1'b0;
        step();
        check("mr_busy", 32'(busy), 32'd1);
        #2;
        rest = 1'b0;
        #1;
        check_reset_vals("mr");
        #1;
        rest = 1'b1;
        step();
        check("mr_no_kill", 32'(ex_if.alu_kill), 32'd0);
        check("mr_idle_busy", 32'(busy), 32'd0);
        check("mr_de_ready", 32'(ex_if.de_ready), 32'd1);

        check("sb_drained", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL sim_timeout: got running, expected finished");
        $fatal(1, "time limit");
    end

endmodule
